// File: rtl/qla_safety_pkg.sv
// Shared types and sizes for the per-axis motor-current plausibility monitor.
package qla_safety_pkg;

  localparam int NUM_AXES = 4;
  localparam int ADC_W    = 16;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SCAN    = 2'd2
  } state_t;

  function automatic logic [ADC_W-1:0] axis_slice(input logic [NUM_AXES*ADC_W-1:0] v,
                                                  input logic [1:0] ax);
    case (ax)
      2'd1:    return v[31:16];
      2'd2:    return v[47:32];
      2'd3:    return v[63:48];
      default: return v[15:0];
    endcase
  endfunction

endpackage

// File: rtl/abs_diff_cmp.sv
// Combinational |a-b| of two offset-binary samples, saturated to 16 bits,
// compared strictly against a fixed threshold.
module abs_diff_cmp
  import qla_safety_pkg::*;
#(
  parameter logic [ADC_W-1:0] THRESH = 16'd2000
) (
  input  logic [ADC_W-1:0] a,
  input  logic [ADC_W-1:0] b,
  output logic             over
);

  logic [ADC_W:0]   diff;
  logic [ADC_W:0]   mag_wide;
  logic [ADC_W-1:0] mag;

  always_comb begin
    diff     = {1'b0, a} - {1'b0, b};
    mag_wide = diff[ADC_W] ? ((ADC_W+1)'(0) - diff) : diff;
    mag      = mag_wide[ADC_W] ? {ADC_W{1'b1}} : mag_wide[ADC_W-1:0];
    over     = (mag > THRESH);
  end

endmodule

// File: rtl/safety_current_check.sv
// Per-axis current plausibility monitor: scans four axes through one shared
// comparator after each ADC sample and latches a sticky disable on persistent error.
//
// state      | meaning
// -----------+--------------------------------------------------
// ST_IDLE    | waiting for sample; busy=0
// ST_CAPTURE | snapshot taken on entry; one cycle before the scan
// ST_SCAN    | one axis per cycle (ax 0..3), then back to IDLE
module safety_current_check
  import qla_safety_pkg::*;
#(
  parameter logic [ADC_W-1:0] THRESH = 16'd2000,
  parameter logic [CNT_W-1:0] LIMIT  = 8'd10
) (
  input  logic                      sysclk,
  input  logic                      reset,
  input  logic [NUM_AXES*ADC_W-1:0] cur_fb,
  input  logic [NUM_AXES*ADC_W-1:0] cur_cmd,
  input  logic                      sample,
  input  logic [NUM_AXES-1:0]       amp_enabled,
  input  logic [NUM_AXES-1:0]       clear,
  output logic [NUM_AXES-1:0]       safety_amp_disable,
  output logic [ADC_W-1:0]          cur1,
  output logic [ADC_W-1:0]          dac1,
  output logic                      busy,
  output logic                      overrun
);

  localparam logic [CNT_W-1:0] LIMIT_M1 = LIMIT - 8'd1;

  state_t                    state;
  logic [1:0]                ax;
  logic [NUM_AXES*ADC_W-1:0] fb_q;
  logic [NUM_AXES*ADC_W-1:0] cmd_q;
  logic [NUM_AXES-1:0]       en_q;
  logic [CNT_W-1:0]          cnt [NUM_AXES];

  logic                      err;
  logic [NUM_AXES-1:0]       scan_hit;
  logic [NUM_AXES-1:0]       set_now;

  abs_diff_cmp #(
    .THRESH (THRESH)
  ) u_cmp (
    .a    (axis_slice(fb_q, ax)),
    .b    (axis_slice(cmd_q, ax)),
    .over (err)
  );

  always_comb begin
    scan_hit = '0;
    set_now  = '0;
    for (int i = 0; i < NUM_AXES; i++) begin
      scan_hit[i] = (state == ST_SCAN) && (ax == 2'(i));
      set_now[i]  = scan_hit[i] && en_q[i] && err && (cnt[i] == LIMIT_M1);
    end
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state              <= ST_IDLE;
      ax                 <= 2'd0;
      fb_q               <= '0;
      cmd_q              <= '0;
      en_q               <= '0;
      busy               <= 1'b0;
      overrun            <= 1'b0;
      cur1               <= '0;
      dac1               <= '0;
      safety_amp_disable <= '0;
      for (int i = 0; i < NUM_AXES; i++) cnt[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sample) begin
            fb_q  <= cur_fb;
            cmd_q <= cur_cmd;
            en_q  <= amp_enabled;
            busy  <= 1'b1;
            state <= ST_CAPTURE;
            if (!safety_amp_disable[0]) begin
              cur1 <= cur_fb[ADC_W-1:0];
              dac1 <= cur_cmd[ADC_W-1:0];
            end
          end
        end
        ST_CAPTURE: begin
          ax    <= 2'd0;
          state <= ST_SCAN;
        end
        ST_SCAN: begin
          ax <= ax + 2'd1;
          if (ax == 2'd3) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase

      // A late sample is recorded even when a clear lands on the same edge.
      if (sample && (state != ST_IDLE)) overrun <= 1'b1;
      else if (|clear)                  overrun <= 1'b0;

      for (int i = 0; i < NUM_AXES; i++) begin
        if (set_now[i]) begin
          safety_amp_disable[i] <= 1'b1;
          if (clear[i]) cnt[i] <= '0;
        end else if (clear[i]) begin
          safety_amp_disable[i] <= 1'b0;
          cnt[i]                <= '0;
        end else if (scan_hit[i]) begin
          if (!en_q[i] || !err) cnt[i] <= '0;
          else                  cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

endmodule
